cam_capture: RTL and testbench
==============================

# cam_capture

Pixel receiver for the camera byte stream (pclk, c_vsync, href, in_data). Tracks frame/line framing, reassembles each two-byte RGB444 pixel, tags it with coordinates and frame/line markers, and buffers it in a small FIFO behind a valid/ready port toward the frame-buffer writer. Flags malformed lines/frames and FIFO overflow with sticky error bits.

## Interface
- H_PIXELS, 640: pixels (byte pairs) per active line
- V_LINES, 480: active lines per frame
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries

- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  capture enable
- c_vsync  in  1  vertical sync, high during vertical blanking
- href  in  1  line valid, high during active bytes
- in_data  in  8  camera byte
- pix_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- pix_x  out  10  pixel column
- pix_y  out  9  pixel row
- pix_sof  out  1  first pixel of frame (x=0,y=0)
- pix_eol  out  1  last pixel of line
- pix_valid  out  1  output entry valid
- pix_ready  in  1  downstream accept
- frame_done  out  1  one-cycle pulse at end of each captured frame
- line_err  out  1  sticky framing error
- ovf_err  out  1  sticky FIFO overflow
- err_clr  in  1  clears line_err and ovf_err

## Operation
- c_vsync, href, in_data registered once at input; all edge detection uses registered copies.
- States: IDLE, WAIT_VS, VBLANK, ACTIVE.
  - IDLE: enable=1 -> WAIT_VS.
  - WAIT_VS: vsync rising edge -> VBLANK (discards partial frame after enable).
  - VBLANK: vsync falling edge -> ACTIVE; clear line/pixel counters.
  - ACTIVE: capture; vsync rising edge -> pulse frame_done, then VBLANK if enable=1 else IDLE.
- enable deassertion mid-frame: current frame finishes; no partial frame abort.
- Byte phase: toggles each cycle href=1; forced to 0 while href=0. Phase 0 byte = {G,R}; phase 1 byte = {4'h0,B}; upper nibble of phase-1 byte ignored.
- Pixel complete on phase-1 byte: pix_x = pixel counter, pix_y = line counter, pix_sof when both 0, pix_eol when x = H_PIXELS-1.
- Line end (href falling edge in ACTIVE): line_err set if phase=1 or pixel count != H_PIXELS; line counter increments; pixel counter clears.
- Frame end: line_err set if line count != V_LINES.
- Pixels beyond H_PIXELS or V_LINES are dropped, not written; counters saturate at max.
- FIFO entry = {sof,eol,y,x,data}, 33 bits. Write when full: entry dropped, ovf_err set.
- pix_valid = FIFO non-empty; entry popped on pix_valid & pix_ready. Output fields are FIFO head, held stable while pix_valid & !pix_ready.
- err_clr and error set in same cycle: set wins.
- Reset: state IDLE, all counters 0, FIFO empty, pix_valid=0, pix_data/pix_x/pix_y=0, pix_sof/pix_eol=0, frame_done=0, line_err=ovf_err=0.

## Timing
- Phase-1 byte on in_data at edge k -> FIFO write at k+2 -> pix_valid high after edge k+3 when FIFO was empty.
- frame_done asserts 2 cycles after c_vsync rising edge at pins.
- Simultaneous FIFO push/pop when full: pop frees slot, push accepted, no overflow.
- Throughput: one pixel per 2 pclk maximum; FIFO absorbs downstream stalls up to depth.

## Configuration
- CAM_CAPTURE_DECIM_EN defined: 2:1 decimation both axes; only pixels with even full-rate x on even full-rate y are written; pix_x/pix_y report decimated coordinates (0..H_PIXELS/2-1, 0..V_LINES/2-1); pix_eol on last kept pixel of line; framing checks still use full-rate counts.
- Undefined: every pixel written, full-rate coordinates.

## Test plan
- Nominal 640x480 frame, pix_ready=1, bytes {G,R}=8'h5A,{0,B}=8'h03 -> 307200 entries, pix_data=12'hA53, first entry sof=1 x=0 y=0, each x=639 eol=1, one frame_done, no errors.
- Line with 1279 bytes -> line_err=1 after href fall; err_clr -> 0.
- Frame of 479 lines -> line_err=1 at vsync rise; frame_done still pulses.
- pix_ready=0 for 40 pixels, FIFO_AW=4 -> first 16 stored, ovf_err=1, stored entries delivered in order on release.
- enable raised mid-frame -> no output until first full frame after next vsync; drop enable mid-frame -> frame completes, then IDLE.
- With CAM_CAPTURE_DECIM_EN -> 76800 entries, last entry x=319 y=239 eol=1.

Source files
------------

// File: rtl/cam_capture.sv
// cam_capture: camera byte stream -> RGB444 pixels tagged with coordinates, buffered in a FIFO.
// Build option `CAM_CAPTURE_DECIM_EN keeps only even columns of even rows (2:1 each axis).
module cam_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int FIFO_AW  = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        c_vsync,
    input  logic        href,
    input  logic [7:0]  in_data,
    output logic [11:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        line_err,
    output logic        ovf_err,
    input  logic        err_clr
);
    // Counters reach one past the nominal count so over-long lines/frames stay detectable.
    localparam int PCW   = $clog2(H_PIXELS + 2);
    localparam int LCW   = $clog2(V_LINES + 2);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [PCW-1:0] H_CNT = PCW'(H_PIXELS);
    localparam logic [PCW-1:0] H_SAT = PCW'(H_PIXELS + 1);
    localparam logic [LCW-1:0] V_CNT = LCW'(V_LINES);
    localparam logic [LCW-1:0] V_SAT = LCW'(V_LINES + 1);
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_VS, VBLANK, ACTIVE} state_t;

    function automatic logic [PCW-1:0] sat_inc_pix(input logic [PCW-1:0] v);
        return (v == H_SAT) ? v : v + PCW'(1);
    endfunction

    function automatic logic [LCW-1:0] sat_inc_line(input logic [LCW-1:0] v);
        return (v == V_SAT) ? v : v + LCW'(1);
    endfunction

    state_t           state, state_nxt;
    logic             vs_p0, vs_p1, href_p0, href_p1, phase_p0;
    logic [7:0]       data_p0, gr_hold;
    logic [PCW-1:0]   pix_cnt;
    logic [LCW-1:0]   line_cnt;
    logic             vs_rise, vs_fall, href_fall;
    logic             cnt_clr, frame_end, line_end, pix_done, in_range;
    logic             vld_p1, vld_p2, keep_p1, sof_p1, eol_p1;
    logic [11:0]      data_p1;
    logic [PCW-1:0]   x_p1;
    logic [LCW-1:0]   y_p1;
    logic [9:0]       xo_p1;
    logic [8:0]       yo_p1;
    logic [32:0]      entry_p2;
    logic [32:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] count;
    logic             full, push, pop, ovf_set, line_err_set;

    // Stage p0: input registers and edge detection on the registered copies
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_p0    <= 1'b0;
            vs_p1    <= 1'b0;
            href_p0  <= 1'b0;
            href_p1  <= 1'b0;
            phase_p0 <= 1'b0;
        end else begin
            vs_p0    <= c_vsync;
            vs_p1    <= vs_p0;
            href_p0  <= href;
            href_p1  <= href_p0;
            phase_p0 <= href_p0 ? ~phase_p0 : 1'b0;
        end
    end

    always_ff @(posedge pclk) data_p0 <= in_data;

    assign vs_rise   = vs_p0 & ~vs_p1;
    assign vs_fall   = ~vs_p0 & vs_p1;
    assign href_fall = ~href_p0 & href_p1;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE:    if (enable) state_nxt = WAIT_VS;
            WAIT_VS: if (!enable) state_nxt = IDLE;
                     else if (vs_rise) state_nxt = VBLANK;
            VBLANK:  if (!enable) state_nxt = IDLE;
                     else if (vs_fall) begin
                         state_nxt = ACTIVE;
                         cnt_clr   = 1'b1;
                     end
            ACTIVE:  if (vs_rise) begin
                         frame_end = 1'b1;
                         state_nxt = enable ? VBLANK : IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    assign line_end = (state == ACTIVE) && href_fall;
    assign pix_done = (state == ACTIVE) && href_p0 && phase_p0;
    assign in_range = (pix_cnt < H_CNT) && (line_cnt < V_CNT);
    assign line_err_set = (line_end && (phase_p0 || pix_cnt != H_CNT))
                        || (frame_end && line_cnt != V_CNT);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            if (cnt_clr || line_end) pix_cnt <= '0;
            else if (pix_done)       pix_cnt <= sat_inc_pix(pix_cnt);
            if (cnt_clr)             line_cnt <= '0;
            else if (line_end)       line_cnt <= sat_inc_line(line_cnt);
        end
    end

    // Stage p1: pixel reassembly with full-rate coordinates
    always_ff @(posedge pclk) begin
        if (href_p0 && !phase_p0) gr_hold <= data_p0;
        data_p1 <= {gr_hold[3:0], gr_hold[7:4], data_p0[3:0]};
        x_p1    <= pix_cnt;
        y_p1    <= line_cnt;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= pix_done && in_range;
    end

    assign sof_p1 = (x_p1 == '0) && (y_p1 == '0);
`ifdef CAM_CAPTURE_DECIM_EN
    localparam logic [PCW-1:0] H_LAST_KEPT = PCW'((H_PIXELS - 1) - ((H_PIXELS - 1) % 2));
    assign keep_p1 = ~x_p1[0] & ~y_p1[0];
    assign eol_p1  = (x_p1 == H_LAST_KEPT);
    assign xo_p1   = 10'(x_p1 >> 1);
    assign yo_p1   = 9'(y_p1 >> 1);
`else
    localparam logic [PCW-1:0] H_LAST = PCW'(H_PIXELS - 1);
    assign keep_p1 = 1'b1;
    assign eol_p1  = (x_p1 == H_LAST);
    assign xo_p1   = 10'(x_p1);
    assign yo_p1   = 9'(y_p1);
`endif

    // Stage p2: FIFO write request in output coordinates
    always_ff @(posedge pclk) entry_p2 <= {sof_p1, eol_p1, yo_p1, xo_p1, data_p1};

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1 && keep_p1;
    end

    assign full      = (count == FULL_CNT);
    assign pix_valid = (count != '0);
    assign pop       = pix_valid && pix_ready;
    assign push      = vld_p2 && (!full || pop);
    assign ovf_set   = vld_p2 && full && !pop;

    always_ff @(posedge pclk) if (push) mem[wr_ptr] <= entry_p2;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign {pix_sof, pix_eol, pix_y, pix_x, pix_data} = pix_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (line_err_set) line_err <= 1'b1;
            else if (err_clr) line_err <= 1'b0;
            if (ovf_set)      ovf_err  <= 1'b1;
            else if (err_clr) ovf_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: scoreboard of expected FIFO entries popped as the DUT delivers them.
module tb_cam_capture;
    localparam int H = 40;
    localparam int V = 4;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        c_vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        pix_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic [11:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid, frame_done, line_err, ovf_err;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;
    int budget = 1000000;
    logic [32:0] exp_q[$];

    cam_capture #(.H_PIXELS(H), .V_LINES(V), .FIFO_AW(4)) dut (
        .pclk(pclk), .rst(rst), .enable(enable), .c_vsync(c_vsync), .href(href),
        .in_data(in_data), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .line_err(line_err), .ovf_err(ovf_err), .err_clr(err_clr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin
        #1;
        if (!rst && pix_valid && pix_ready) begin
            check("entry_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("entry", {pix_sof, pix_eol, pix_y, pix_x, pix_data}, exp_q.pop_front());
        end
        if (frame_done) fd_count++;
    end

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge pclk);
        c_vsync = vs;
        href    = hr;
        in_data = d;
    endtask

    task automatic settle();
        @(negedge pclk);
        #1;
    endtask

    task automatic expect_pixel(input int x, input int y, input logic [11:0] d);
        int xo, yo;
        logic keep, eol;
        if (x >= H || y >= V) return;
`ifdef CAM_CAPTURE_DECIM_EN
        keep = (x % 2 == 0) && (y % 2 == 0);
        xo = x / 2;
        yo = y / 2;
        eol = (x == H - 2);
`else
        keep = 1'b1;
        xo = x;
        yo = y;
        eol = (x == H - 1);
`endif
        if (keep && budget > 0) begin
            exp_q.push_back({(x == 0 && y == 0), eol, 9'(yo), 10'(xo), d});
            budget--;
        end
    endtask

    task automatic send_line(input int nbytes, input int y, input bit cap, input bit nominal);
        logic [3:0] r, g, bl;
        int x;
        for (int i = 0; i < nbytes; i++) begin
            x  = i / 2;
            r  = nominal ? 4'hA : 4'(x ^ y);
            g  = nominal ? 4'h5 : 4'(x + 3);
            bl = nominal ? 4'h3 : 4'(3 * x + y);
            if (i % 2 == 0) cyc(1'b0, 1'b1, {g, r});
            else begin
                cyc(1'b0, 1'b1, {(nominal ? 4'h0 : 4'h9), bl});
                if (cap) expect_pixel(x, y, {r, g, bl});
            end
        end
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_lines(input int first, input int last, input bit cap, input bit nominal);
        for (int y = first; y <= last; y++) send_line(2 * H, y, cap, nominal);
    endtask

    task automatic vsync_pulse(input logic exp_done);
        cyc(1'b1, 1'b0, 8'h00);
        settle();
        check("frame_done_early", frame_done, 0);
        settle();
        check("frame_done", frame_done, exp_done);
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_errors();
        @(negedge pclk);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || pix_valid); i++) settle();
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", pix_valid, 0);
    endtask

    initial begin
        repeat (3) settle();
        check("rst_valid", pix_valid, 0);
        check("rst_fields", {pix_sof, pix_eol, pix_y, pix_x, pix_data}, 0);
        check("rst_flags", {frame_done, line_err, ovf_err}, 0);
        @(negedge pclk);
        rst = 1'b0;

        // Enter capture: the frame after the first vsync is the first one stored.
        enable = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        vsync_pulse(1'b0);

        // Nominal frame 5A/03 -> A53, then a frame with varying content.
        send_lines(0, V - 1, 1'b1, 1'b1);
        vsync_pulse(1'b1);
        wait_drain();
        check("nominal_line_err", line_err, 0);
        check("nominal_ovf_err", ovf_err, 0);
        check("nominal_fd", fd_count, 1);
        send_lines(0, V - 1, 1'b1, 1'b0);
        vsync_pulse(1'b1);
        wait_drain();
        check("pattern_errs", {line_err, ovf_err}, 0);

        // Short line, then over-long line, each clearable.
        send_line(2 * H - 1, 0, 1'b1, 1'b0);
        check("short_line_err", line_err, 1);
        clear_errors();
        check("short_line_clr", line_err, 0);
        send_line(2 * H + 4, 1, 1'b1, 1'b0);
        check("long_line_err", line_err, 1);
        clear_errors();
        check("long_line_clr", line_err, 0);
        send_lines(2, V - 1, 1'b1, 1'b0);
        vsync_pulse(1'b1);
        wait_drain();
        check("line_test_frame_err", line_err, 0);

        // Frame one line short: error flagged at vsync, frame_done still pulses.
        send_lines(0, V - 2, 1'b1, 1'b0);
        check("short_frame_pre", line_err, 0);
        vsync_pulse(1'b1);
        check("short_frame_err", line_err, 1);
        wait_drain();
        clear_errors();
        check("short_frame_clr", line_err, 0);

        // Downstream stall across a full line: FIFO keeps the first 16 entries.
        pix_ready = 1'b0;
        budget = 16;
        send_line(2 * H, 0, 1'b1, 1'b0);
        repeat (4) settle();
        check("stall_ovf", ovf_err, 1);
        check("stall_valid", pix_valid, 1);
        check("stall_head", {pix_sof, pix_eol, pix_y, pix_x, pix_data}, exp_q[0]);
        repeat (5) settle();
        check("stall_hold", {pix_sof, pix_eol, pix_y, pix_x, pix_data}, exp_q[0]);
        check("stall_queue", exp_q.size(), 16);
        budget = 1000000;
        pix_ready = 1'b1;
        send_lines(1, V - 1, 1'b1, 1'b0);
        vsync_pulse(1'b1);
        wait_drain();
        check("stall_ovf_sticky", ovf_err, 1);
        clear_errors();
        check("stall_ovf_clr", ovf_err, 0);

        // Drop enable mid-frame: that frame completes, then capture stops.
        send_lines(0, 1, 1'b1, 1'b0);
        enable = 1'b0;
        send_lines(2, V - 1, 1'b1, 1'b0);
        vsync_pulse(1'b1);
        wait_drain();

        // Raise enable mid-frame: nothing stored until the next full frame.
        send_lines(0, 1, 1'b0, 1'b0);
        enable = 1'b1;
        send_lines(2, V - 1, 1'b0, 1'b0);
        vsync_pulse(1'b0);
        check("mid_enable_quiet", pix_valid, 0);
        send_lines(0, V - 1, 1'b1, 1'b1);
        vsync_pulse(1'b1);
        wait_drain();
        check("final_fd", fd_count, 7);
        check("final_errs", {line_err, ovf_err}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
